vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 168 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical FSMs, registered syncs, blanking and coordinates.
// Optional linear framebuffer address counter enabled by defining VGA_PIXEL_ADDR_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pix_en,
  output logic              hs,
  output logic              vs,
  output logic              blank_n,
  output logic              active,
  output logic [10:0]       x,
  output logic [9:0]        y,
  output logic              line_start,
  output logic              frame_start,
  output logic [ADDR_W-1:0] pixel_addr
);

  localparam int unsigned HC_W    = 11;
  localparam int unsigned VC_W    = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last count of each region, used as the FSM exit condition
  localparam logic [HC_W-1:0] H_ACT_LAST   = HC_W'(H_ACTIVE - 1);
  localparam logic [HC_W-1:0] H_FRONT_LAST = HC_W'(H_ACTIVE + H_FP - 1);
  localparam logic [HC_W-1:0] H_SYNC_LAST  = HC_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HC_W-1:0] H_LAST       = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT_LAST   = VC_W'(V_ACTIVE - 1);
  localparam logic [VC_W-1:0] V_FRONT_LAST = VC_W'(V_ACTIVE + V_FP - 1);
  localparam logic [VC_W-1:0] V_SYNC_LAST  = VC_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VC_W-1:0] V_LAST       = VC_W'(V_TOTAL - 1);

  generate
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        H_TOTAL > (1 << HC_W) || V_TOTAL > (1 << VC_W)) begin : g_bad_params
      $error("vga_timing_gen: illegal timing parameters");
    end
  endgenerate

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCS, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCS, V_BACK} v_state_t;

  h_state_t        h_state, h_state_nxt;
  v_state_t        v_state, v_state_nxt;
  logic [HC_W-1:0] h_cnt, h_cnt_nxt;
  logic [VC_W-1:0] v_cnt, v_cnt_nxt;
  logic            h_end;
  logic            in_act;
  logic            hs_nxt, vs_nxt, blank_nxt, ls_nxt, fs_nxt;
  logic [10:0]     x_nxt;
  logic [9:0]      y_nxt;

  // State, counter and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_state     <= H_ACT;
      v_state     <= V_ACT;
      h_cnt       <= '0;
      v_cnt       <= '0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      blank_n     <= 1'b0;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_state     <= h_state_nxt;
      v_state     <= v_state_nxt;
      h_cnt       <= h_cnt_nxt;
      v_cnt       <= v_cnt_nxt;
      hs          <= hs_nxt;
      vs          <= vs_nxt;
      blank_n     <= blank_nxt;
      active      <= blank_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
    end
  end

  // Next-state: outputs describe the pre-increment position on each pixel tick
  always_comb begin
    h_state_nxt = h_state;
    v_state_nxt = v_state;
    h_cnt_nxt   = h_cnt;
    v_cnt_nxt   = v_cnt;
    h_end       = 1'b0;
    hs_nxt      = hs;
    vs_nxt      = vs;
    blank_nxt   = blank_n;
    x_nxt       = x;
    y_nxt       = y;
    ls_nxt      = 1'b0;
    fs_nxt      = 1'b0;
    in_act      = (h_state == H_ACT) && (v_state == V_ACT);

    if (pix_en) begin
      hs_nxt    = (h_state == H_SYNCS) ? HS_POL : ~HS_POL;
      vs_nxt    = (v_state == V_SYNCS) ? VS_POL : ~VS_POL;
      blank_nxt = in_act;
      x_nxt     = in_act ? h_cnt : '0;
      y_nxt     = in_act ? v_cnt : '0;
      ls_nxt    = (h_cnt == '0);
      fs_nxt    = (h_cnt == '0) && (v_cnt == '0);

      case (h_state)
        H_ACT:   if (h_cnt == H_ACT_LAST)   h_state_nxt = H_FRONT;
        H_FRONT: if (h_cnt == H_FRONT_LAST) h_state_nxt = H_SYNCS;
        H_SYNCS: if (h_cnt == H_SYNC_LAST)  h_state_nxt = H_BACK;
        H_BACK:  if (h_cnt == H_LAST)       h_state_nxt = H_ACT;
        default: h_state_nxt = H_ACT;
      endcase

      h_end     = (h_cnt == H_LAST);
      h_cnt_nxt = h_end ? '0 : h_cnt + HC_W'(1);

      if (h_end) begin
        v_cnt_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VC_W'(1);
        case (v_state)
          V_ACT:   if (v_cnt == V_ACT_LAST)   v_state_nxt = V_FRONT;
          V_FRONT: if (v_cnt == V_FRONT_LAST) v_state_nxt = V_SYNCS;
          V_SYNCS: if (v_cnt == V_SYNC_LAST)  v_state_nxt = V_BACK;
          V_BACK:  if (v_cnt == V_LAST)       v_state_nxt = V_ACT;
          default: v_state_nxt = V_ACT;
        endcase
      end
    end
  end

`ifdef VGA_PIXEL_ADDR_EN
  // Running address: restarts at each frame origin, steps once per active pixel
  logic [ADDR_W-1:0] addr_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel_addr <= '0;
      addr_cnt   <= '0;
    end else if (pix_en && in_act) begin
      if (fs_nxt) begin
        pixel_addr <= '0;
        addr_cnt   <= ADDR_W'(1);
      end else begin
        pixel_addr <= addr_cnt;
        addr_cnt   <= addr_cnt + ADDR_W'(1);
      end
    end
  end
`else
  assign pixel_addr = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a tiny 8x6 raster; reference is an arithmetic position model.
module tb_vga_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b0;
`ifdef VGA_PIXEL_ADDR_EN
  localparam bit ADDR_EN = 1'b1;
`else
  localparam bit ADDR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pix_en = 1'b0;
  logic        hs, vs, blank_n, active, line_start, frame_start;
  logic [10:0] x;
  logic [9:0]  y;
  logic [18:0] pixel_addr;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .ADDR_W(19)
  ) dut (
    .clock(clock), .reset(reset), .pix_en(pix_en),
    .hs(hs), .vs(vs), .blank_n(blank_n), .active(active),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .pixel_addr(pixel_addr)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fs = -1;
  int fs_period = -1;

  // Model: linear position within the frame plus last expected output values
  int mpos = 0;
  int e_hs, e_vs, e_blank, e_x, e_y, e_ls, e_fs, e_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mpos = 0;
    e_hs = !HPOL; e_vs = !VPOL;
    e_blank = 0; e_x = 0; e_y = 0; e_ls = 0; e_fs = 0; e_addr = 0;
  endtask

  task automatic model_tick();
    int h, v;
    bit act;
    if (reset) begin
      model_reset();
    end else if (pix_en) begin
      h = mpos % HT;
      v = mpos / HT;
      act = (h < HA) && (v < VA);
      e_hs = (h >= HA + HF && h < HA + HF + HS) ? HPOL : !HPOL;
      e_vs = (v >= VA + VF && v < VA + VF + VS) ? VPOL : !VPOL;
      e_blank = act;
      e_x = act ? h : 0;
      e_y = act ? v : 0;
      e_ls = (h == 0);
      e_fs = (mpos == 0);
      if (act && ADDR_EN) e_addr = v * HA + h;
      mpos = (mpos + 1) % (HT * VT);
    end else begin
      e_ls = 0;
      e_fs = 0;
    end
  endtask

  task automatic check_all();
    chk("hs", 32'(hs), e_hs);
    chk("vs", 32'(vs), e_vs);
    chk("blank_n", 32'(blank_n), e_blank);
    chk("active", 32'(active), e_blank);
    chk("x", 32'(x), e_x);
    chk("y", 32'(y), e_y);
    chk("line_start", 32'(line_start), e_ls);
    chk("frame_start", 32'(frame_start), e_fs);
    chk("pixel_addr", 32'(pixel_addr), e_addr);
  endtask

  task automatic tick(input bit en);
    pix_en = en;
    @(posedge clock);
    cyc++;
    #1;
    model_tick();
    check_all();
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) fs_period = cyc - last_fs;
      last_fs = cyc;
    end
  endtask

  initial begin
    // Async reset takes effect without a clock edge
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    tick(1'b0);
    tick(1'b1);
    reset = 1'b0;

    // Two full frames at one pixel per clock
    last_fs = -1;
    fs_period = -1;
    for (int i = 0; i < 2 * HT * VT; i++) tick(1'b1);
    chk("fs_period_full_rate", fs_period, HT * VT);

    // Half-rate enable doubles the frame period
    last_fs = -1;
    fs_period = -1;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      tick(1'b1);
      tick(1'b0);
    end
    chk("fs_period_half_rate", fs_period, 2 * HT * VT);

    // Mid-frame reset at h=2, v=1
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    for (int i = 0; i < HT + 2; i++) tick(1'b1);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < 3; i++) tick(1'b1);
    reset = 1'b0;
    tick(1'b1);
    chk("rst_rel_x", 32'(x), 0);
    chk("rst_rel_y", 32'(y), 0);
    chk("rst_rel_fs", 32'(frame_start), 1);

    // Random enable with occasional resets
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) reset = 1'b1;
      tick(1'($urandom_range(0, 1)));
      reset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
